// File: rtl/pipe_skid_register_pkg.sv
// Shared lc3b pipeline types: per-stage payload structs/widths and skid-stage helpers.
package lc3b_types;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned CTRL_WIDTH = 20;
    localparam int unsigned CC_WIDTH   = 3;
    localparam int unsigned DEST_WIDTH = 3;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] address;
        logic [WORD_WIDTH-1:0] next_instr;
        logic [WORD_WIDTH-1:0] ir;
        logic                  valid;
    } if_id_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] address;
        logic [WORD_WIDTH-1:0] next_instr;
        logic [CTRL_WIDTH-1:0] control;
        logic [WORD_WIDTH-1:0] ir;
        logic [DEST_WIDTH-1:0] dest;
        logic                  valid;
    } id_ex_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] address;
        logic [WORD_WIDTH-1:0] next_instr;
        logic [CTRL_WIDTH-1:0] control;
        logic [CC_WIDTH-1:0]   cc;
        logic [WORD_WIDTH-1:0] alu_out;
        logic [WORD_WIDTH-1:0] ir;
        logic [DEST_WIDTH-1:0] dest;
        logic                  valid;
    } ex_mem_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] next_instr;
        logic [CTRL_WIDTH-1:0] control;
        logic [CC_WIDTH-1:0]   cc;
        logic [WORD_WIDTH-1:0] alu_out;
        logic [WORD_WIDTH-1:0] mem_data;
        logic [WORD_WIDTH-1:0] ir;
        logic [DEST_WIDTH-1:0] dest;
        logic                  valid;
    } mem_wb_t;

    localparam int unsigned IF_ID_WIDTH  = $bits(if_id_t);
    localparam int unsigned ID_EX_WIDTH  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_WIDTH = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_WIDTH = $bits(mem_wb_t);

    // Occupancy encoding is {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } skid_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_skid_register_skid_entry.sv
// One payload slot: data register plus valid bit with load and clear.
module skid_entry #(
    parameter int unsigned             DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]   RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] d,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    // Load wins over clear; clear drops the valid bit but keeps the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_skid_register.sv
// Generic lc3b pipeline stage register with valid/ready, two-entry skid and flush.
// Optional: define PIPE_SKID_STALL_COUNT_EN to add a saturating stall_count output.
import lc3b_types::*;

module pipe_skid_register #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  down_valid,
    input  logic                  down_ready,
    output logic [DATA_WIDTH-1:0] down_data
`ifdef PIPE_SKID_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    skid_state_e           state_q, state_d;
    logic                  main_load, main_clr, skid_load, skid_clr;
    logic [DATA_WIDTH-1:0] main_d;
    logic                  main_valid, skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  up_xfer, down_xfer;

    assign up_ready   = ~skid_valid;
    assign down_valid = main_valid;
    assign up_xfer    = up_valid & up_ready;
    assign down_xfer  = main_valid & down_ready;

    skid_entry #(.DATA_WIDTH(DATA_WIDTH), .RESET_DATA(RESET_DATA)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .valid (main_valid),
        .data  (down_data)
    );

    skid_entry #(.DATA_WIDTH(DATA_WIDTH), .RESET_DATA(RESET_DATA)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (up_data),
        .valid (skid_valid),
        .data  (skid_data)
    );

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and entry load/clear strobes; flush empties without loading.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_d    = up_data;
        case (state_q)
            ST_EMPTY: begin
                if (up_xfer) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (up_xfer && down_xfer) begin
                    main_load = 1'b1;
                end else if (up_xfer) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end else if (down_xfer) begin
                    main_clr  = 1'b1;
                    state_d   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (down_xfer) begin
                    main_load = 1'b1;
                    main_d    = skid_data;
                    skid_clr  = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            default: begin
                state_d  = ST_EMPTY;
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end
    end

`ifdef PIPE_SKID_STALL_COUNT_EN
    // Saturating count of cycles where downstream holds off a presented payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (main_valid && !down_ready) begin
            stall_count <= sat_inc16(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_register.sv
// Scoreboard bench for pipe_skid_register: driver pushes accepted payloads, monitor pops on down transfers.
module tb_pipe_skid_register;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset, flush, up_valid, up_ready, down_valid, down_ready;
    logic [DW-1:0] up_data, down_data;
`ifdef PIPE_SKID_STALL_COUNT_EN
    logic [15:0]   stall_count;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_skid_register #(.DATA_WIDTH(DW), .RESET_DATA('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .down_data   (down_data)
`ifdef PIPE_SKID_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; acc is the hand-predicted acceptance of up_data.
    task automatic drive(input logic rst, input logic fl, input logic uv,
                         input logic [DW-1:0] ud, input logic dr, input logic acc);
        reset = rst; flush = fl; up_valid = uv; up_data = ud; down_ready = dr;
        if (uv && !rst) check("up_ready", 32'(up_ready), 32'(acc));
        @(negedge clk);
        #1;
        if (rst || fl) exp_q.delete();
        if (acc && uv && !rst && !fl) exp_q.push_back(ud);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream transfer must match the oldest expected payload.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && down_valid && down_ready) begin
                check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("down_data_order", 32'(down_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;

        // 1: reset
        drive(1, 0, 0, 16'h0, 0, 0);
        drive(1, 0, 0, 16'h0, 0, 0);
        check("rst_down_valid", 32'(down_valid), 32'd0);
        check("rst_down_data",  32'(down_data),  32'h0);
        check("rst_up_ready",   32'(up_ready),   32'd1);

        // 2: streaming, one per cycle, no bubbles
        drive(0, 0, 1, 16'h1111, 1, 1);
        check("s1_valid", 32'(down_valid), 32'd1);
        check("s1_data",  32'(down_data),  32'h1111);
        drive(0, 0, 1, 16'h2222, 1, 1);
        check("s2_data",  32'(down_data),  32'h2222);
        drive(0, 0, 1, 16'h3333, 1, 1);
        check("s3_data",  32'(down_data),  32'h3333);
        drive(0, 0, 0, 16'h0, 1, 0);
        check("s_drained", 32'(down_valid), 32'd0);

        // 3: backpressure into skid and drain in order
        drive(0, 0, 1, 16'hAAAA, 0, 1);
        drive(0, 0, 1, 16'hBBBB, 0, 1);
        check("two_up_ready", 32'(up_ready),  32'd0);
        check("two_data",     32'(down_data), 32'hAAAA);
        drive(0, 0, 1, 16'hDDDD, 0, 0);
        check("stall_hold",   32'(down_data), 32'hAAAA);
        drive(0, 0, 0, 16'h0, 1, 0);
        check("drain_up_ready", 32'(up_ready),  32'd1);
        check("drain_data",     32'(down_data), 32'hBBBB);
        drive(0, 0, 0, 16'h0, 1, 0);
        check("drain_empty",    32'(down_valid), 32'd0);

        // 4: flush from TWO, then flush in ONE with simultaneous transfers
        drive(0, 0, 1, 16'hEEEE, 0, 1);
        drive(0, 0, 1, 16'hFFFF, 0, 1);
        drive(0, 1, 1, 16'hCCCC, 0, 0);
        check("fl2_valid",    32'(down_valid), 32'd0);
        check("fl2_up_ready", 32'(up_ready),   32'd1);
        check("fl2_hold",     32'(down_data),  32'hEEEE);
        drive(0, 0, 1, 16'h1234, 0, 1);
        drive(0, 1, 1, 16'h5678, 1, 1);
        check("fl1_valid", 32'(down_valid), 32'd0);
        check("fl1_hold",  32'(down_data),  32'h1234);
        drive(0, 0, 0, 16'h0, 1, 0);
        drive(0, 0, 0, 16'h0, 1, 0);
        check("fl_idle_valid", 32'(down_valid), 32'd0);

        // 5: reset beats flush
        drive(0, 0, 1, 16'h5555, 0, 1);
        check("pre_rst_data", 32'(down_data), 32'h5555);
        drive(1, 1, 0, 16'h0, 0, 0);
        check("rf_valid",    32'(down_valid), 32'd0);
        check("rf_data",     32'(down_data),  32'h0);
        check("rf_up_ready", 32'(up_ready),   32'd1);
        drive(0, 0, 1, 16'h0F0F, 1, 1);
        check("post_rf_data", 32'(down_data), 32'h0F0F);
        drive(0, 0, 0, 16'h0, 1, 0);
        check("post_rf_empty", 32'(down_valid), 32'd0);

`ifdef PIPE_SKID_STALL_COUNT_EN
        // 6: stall counter, flush persistence, saturation, reset clear
        drive(1, 0, 0, 16'h0, 0, 0);
        check("sc_reset", 32'(stall_count), 32'd0);
        drive(0, 0, 1, 16'h9999, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 16'h0, 0, 0);
        check("sc_five", 32'(stall_count), 32'd5);
        drive(0, 1, 0, 16'h0, 0, 0);
        check("sc_flush_keep", 32'(stall_count), 32'd6);
        drive(0, 0, 1, 16'h7777, 0, 1);
        for (int i = 0; i < 70000; i++) drive(0, 0, 0, 16'h0, 0, 0);
        check("sc_sat", 32'(stall_count), 32'h0000FFFF);
        drive(1, 0, 0, 16'h0, 0, 0);
        check("sc_clear", 32'(stall_count), 32'd0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
